// File: rtl/mips_hazard_ctrl.sv
// ============================================================================
// Module   : mips_hazard_ctrl
// Brief    : 5-stage MIPS hazard/freeze controller: load-use stall, branch
//            flush, EXE forwarding selects, cache-miss freeze and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  imem_hit,
    input  logic                  dmem_hit,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  freeze,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  miss_error,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int MC_W = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);
    localparam logic [MC_W-1:0]       c_TIMEOUT  = MC_W'(MISS_TIMEOUT);
    localparam logic [MC_W-1:0]       c_MC_ONE   = MC_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_ONE  = CNT_W'(1);
    localparam logic [REG_ADDR_W-1:0] c_REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    shadow_t r_s1, r_s2, r_s3;
    shadow_t w_s1_nxt;
    state_t  r_state, w_state_nxt;
    logic [MC_W-1:0]  r_miss_cnt, w_miss_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_miss;
    logic w_freeze;
    logic w_load_use;
    logic w_branch;
    logic w_stall;
    logic w_unused;

    function automatic logic match(input shadow_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.reg_write & (s.dest == r) & (r != c_REG_ZERO);
    endfunction

    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input shadow_t s1, input shadow_t s2,
                                           input shadow_t s3,
                                           input logic [REG_ADDR_W-1:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (s1.valid) begin
            if (match(s2, r))
                sel = 2'b10;
            else if (match(s3, r))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_miss   = ~imem_hit | ~dmem_hit;
    assign w_freeze = w_miss | (r_state == ST_ERR);

    assign w_load_use = id_valid & r_s1.valid & r_s1.mem_read & (r_s1.dest != c_REG_ZERO)
                      & ((r_s1.dest == id_rs) | (id_uses_rt & (r_s1.dest == id_rt)));

    assign w_branch = ex_branch_taken & ~w_freeze;
    assign w_stall  = w_load_use & ~ex_branch_taken & ~w_freeze;

    always_comb begin
        w_s1_nxt = '0;
        if (!(w_stall || w_branch)) begin
            w_s1_nxt.valid     = id_valid;
            w_s1_nxt.rs        = id_rs;
            w_s1_nxt.rt        = id_rt;
            w_s1_nxt.dest      = id_dest;
            w_s1_nxt.reg_write = id_reg_write;
            w_s1_nxt.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else if (!w_freeze) begin
            r_s3 <= r_s2;
            r_s2 <= r_s1;
            r_s1 <= w_s1_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_RUN;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_miss_cnt_nxt = r_miss_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_miss) begin
                    w_state_nxt    = ST_MISS;
                    w_miss_cnt_nxt = c_MC_ONE;
                end
            end
            ST_MISS: begin
                if (!w_miss) begin
                    w_state_nxt    = ST_RUN;
                    w_miss_cnt_nxt = '0;
                end else if (r_miss_cnt == c_TIMEOUT) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_miss_cnt_nxt = r_miss_cnt + c_MC_ONE;
                end
            end
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + c_CNT_ONE;
    end

    assign stall_pc     = w_stall;
    assign stall_if_id  = w_stall;
    assign bubble_id_ex = w_stall;
    assign flush_if_id  = w_branch;
    assign flush_id_ex  = w_branch;
    assign freeze       = w_freeze;
    assign fwd_a        = fwd_sel(r_s1, r_s2, r_s3, r_s1.rs);
    assign fwd_b        = fwd_sel(r_s1, r_s2, r_s3, r_s1.rt);
    assign miss_error   = (r_state == ST_ERR);
    assign stall_count  = r_stall_count;

    // Source fields of older entries are carried for observability only.
    assign w_unused = ^{r_s2.rs, r_s2.rt, r_s2.mem_read, r_s3.rs, r_s3.rt, r_s3.mem_read};

endmodule

`default_nettype wire

// File: tb/tb_mips_hazard_ctrl.sv
// ============================================================================
// Module   : tb_mips_hazard_ctrl
// Brief    : Self-checking bench for mips_hazard_ctrl with an in-flight
//            instruction queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_hazard_ctrl;

    localparam int MISS_TIMEOUT = 255;

    logic       clk, rst;
    logic       id_valid, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       ex_branch_taken, imem_hit, dmem_hit;
    logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze;
    logic [1:0] fwd_a, fwd_b;
    logic       miss_error;
    logic [15:0] stall_count;

    mips_hazard_ctrl #(.REG_ADDR_W(5), .MISS_TIMEOUT(MISS_TIMEOUT), .CNT_W(16)) dut (
        .Clk(clk), .Rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .imem_hit(imem_hit), .dmem_hit(dmem_hit),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .miss_error(miss_error), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
                  freeze, fwd_a, fwd_b, miss_error};

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [4:0] rs, rt, d;
        bit       rw, mr;
    } instr_t;

    instr_t inflight[$];   // [0]=EXE, [1]=MEM, [2]=WB
    bit     m_err;
    int     m_run;
    int     m_cnt;
    bit     m_stall, m_br, m_frz;
    logic [10:0] exp_vec;
    logic [15:0] exp_cnt;

    function automatic void model_reset();
        instr_t e;
        e = '{v: 0, rs: 0, rt: 0, d: 0, rw: 0, mr: 0};
        inflight.delete();
        repeat (3) inflight.push_back(e);
        m_err = 0;
        m_run = 0;
        m_cnt = 0;
    endfunction

    function automatic bit writes(instr_t e, bit [4:0] r);
        return e.v && e.rw && (e.d == r) && (r != 0);
    endfunction

    function automatic bit [1:0] src(bit [4:0] r);
        if (!inflight[0].v) return 2'b00;
        if (writes(inflight[1], r)) return 2'b10;
        if (writes(inflight[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void calc();
        instr_t ex;
        bit lu;
        ex    = inflight[0];
        m_frz = !imem_hit || !dmem_hit || m_err;
        lu    = id_valid && ex.v && ex.mr && (ex.d != 0) &&
                ((ex.d == id_rs) || (id_uses_rt && ex.d == id_rt));
        m_br    = ex_branch_taken && !m_frz;
        m_stall = lu && !ex_branch_taken && !m_frz;
        exp_vec = {m_stall, m_stall, m_stall, m_br, m_br, m_frz,
                   src(ex.rs), src(ex.rt), m_err};
        exp_cnt = m_cnt[15:0];
    endfunction

    function automatic void model_step();
        instr_t n;
        calc();
        if (!m_frz) begin
            n = '{v: id_valid, rs: id_rs, rt: id_rt, d: id_dest,
                  rw: id_reg_write, mr: id_mem_read};
            if (m_stall || m_br) n.v = 0;
            inflight.push_front(n);
            void'(inflight.pop_back());
        end
        if (!imem_hit || !dmem_hit) m_run++;
        else m_run = 0;
        if (m_run > MISS_TIMEOUT) m_err = 1;
        if (m_stall && m_cnt < 65535) m_cnt++;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urt,
                         input bit [4:0] d, input bit rw, input bit mr,
                         input bit bt, input bit ih, input bit dh);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dest = d;
        id_reg_write = rw; id_mem_read = mr;
        ex_branch_taken = bt; imem_hit = ih; dmem_hit = dh;
        calc();
        #1;
    endtask

    task automatic nop(input bit ih = 1, input bit dh = 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, ih, dh);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_dest = 0;
        id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
        imem_hit = 1; dmem_hit = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        nop();
        n_checks++;
        if (obs !== 11'h000) $display("FAIL reset_outputs obs=%b exp=%b", obs, 11'h000);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", stall_count);
        else n_pass++;
        nop(0, 1);
        n_checks++;
        if (obs !== 11'h020) $display("FAIL reset_freeze_follows_hit obs=%b exp=%b", obs, 11'h020);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 2, 1, 1, 0, 1, 1);          // lw $2
        drive(1, 2, 4, 1, 3, 1, 0, 0, 1, 1);          // add $3,$2,$4
        n_checks++;
        if (obs[10:8] !== 3'b111) $display("FAIL lu_stall got=%b exp=111", obs[10:8]);
        else n_pass++;
        n_checks++;
        if (obs !== exp_vec) $display("FAIL lu_model obs=%b exp=%b", obs, exp_vec);
        else n_pass++;
        drive(1, 2, 4, 1, 3, 1, 0, 0, 1, 1);          // add held in ID
        n_checks++;
        if (stall_pc !== 1'b0) $display("FAIL lu_single_cycle got=%b exp=0", stall_pc);
        else n_pass++;
        nop();
        n_checks++;
        if (fwd_a !== 2'b01) $display("FAIL lu_fwd_wb got=%b exp=01", fwd_a);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd1) $display("FAIL lu_count got=%0d exp=1", stall_count);
        else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 1, 1, 1, 5, 1, 0, 0, 1, 1);          // add $5,$1,$1
        drive(1, 5, 5, 1, 6, 1, 0, 0, 1, 1);          // sub $6,$5,$5
        nop();
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b1010 || stall_pc !== 1'b0)
            $display("FAIL fwd_mem got=%b%b stall=%b exp=1010 stall=0", fwd_a, fwd_b, stall_pc);
        else n_pass++;
        drive(1, 1, 1, 1, 5, 1, 0, 0, 1, 1);
        drive(1, 1, 1, 1, 7, 1, 0, 0, 1, 1);          // independent
        drive(1, 5, 5, 1, 6, 1, 0, 0, 1, 1);
        nop();
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0101) $display("FAIL fwd_wb got=%b%b exp=0101", fwd_a, fwd_b);
        else n_pass++;
    endtask

    task automatic test_reg0();
        do_reset();
        drive(1, 1, 1, 1, 0, 1, 0, 0, 1, 1);          // write $0
        drive(1, 0, 0, 1, 8, 1, 0, 0, 1, 1);          // read $0
        nop();
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reg0_fwd got=%b%b exp=0000", fwd_a, fwd_b);
        else n_pass++;
        drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 1);          // lw $0
        drive(1, 0, 0, 1, 9, 1, 0, 0, 1, 1);
        n_checks++;
        if (stall_pc !== 1'b0) $display("FAIL reg0_no_stall got=%b exp=0", stall_pc);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 0, 0, 0, 2, 1, 1, 0, 1, 1);          // lw $2
        drive(1, 2, 4, 1, 3, 1, 0, 1, 1, 1);          // consumer + branch taken
        n_checks++;
        if ({flush_if_id, flush_id_ex, stall_pc, bubble_id_ex} !== 4'b1100)
            $display("FAIL br_override got=%b exp=1100",
                     {flush_if_id, flush_id_ex, stall_pc, bubble_id_ex});
        else n_pass++;
        nop();
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL br_s1_invalid got=%b%b exp=0000", fwd_a, fwd_b);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);          // branch while frozen
        n_checks++;
        if ({flush_if_id, freeze} !== 2'b01) $display("FAIL br_frozen got=%b exp=01", {flush_if_id, freeze});
        else n_pass++;
    endtask

    task automatic test_miss();
        do_reset();
        drive(1, 1, 1, 1, 5, 1, 0, 0, 1, 1);
        drive(1, 5, 5, 1, 6, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            nop(0, 1);
            n_checks++;
            if ({freeze, fwd_a} !== 3'b110) $display("FAIL miss_hold cyc=%0d got=%b exp=110", i, {freeze, fwd_a});
            else n_pass++;
        end
        nop();
        n_checks++;
        if ({freeze, fwd_a} !== 3'b010) $display("FAIL miss_release got=%b exp=010", {freeze, fwd_a});
        else n_pass++;
        nop();
        n_checks++;
        if (fwd_a !== 2'b00) $display("FAIL miss_advance got=%b exp=00", fwd_a);
        else n_pass++;
        for (int i = 0; i < 256; i++) begin
            nop(1, 0);
            n_checks++;
            if (obs !== exp_vec) $display("FAIL timeout_model cyc=%0d obs=%b exp=%b", i, obs, exp_vec);
            else n_pass++;
        end
        nop();
        n_checks++;
        if ({miss_error, freeze} !== 2'b11) $display("FAIL timeout_err got=%b exp=11", {miss_error, freeze});
        else n_pass++;
        nop();
        n_checks++;
        if ({miss_error, freeze} !== 2'b11) $display("FAIL err_sticky got=%b exp=11", {miss_error, freeze});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 0, 0, 2, 1, 1, 0, 1, 1);          // lw $2
        nop(0, 1);                                     // enter MISS with lw in EXE
        @(negedge clk);
        id_valid = 1; id_rs = 2; id_uses_rt = 0; imem_hit = 1; dmem_hit = 1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'h000 || stall_count !== 16'd0)
            $display("FAIL reset_mid obs=%b cnt=%0d exp=0 cnt=0", obs, stall_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2, 0, 0, 3, 1, 0, 0, 1, 1);
        n_checks++;
        if (stall_pc !== 1'b0) $display("FAIL reset_mid_no_stall got=%b exp=0", stall_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) != 0));
            n_checks++;
            if (obs !== exp_vec) $display("FAIL rand_outputs cyc=%0d obs=%b exp=%b", i, obs, exp_vec);
            else n_pass++;
            n_checks++;
            if (stall_count !== exp_cnt) $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, stall_count, exp_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_forward();
        test_reg0();
        test_branch();
        test_miss();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
- Parametrised pipeline hazard and freeze controller for the 5-stage MIPS core (IF, ID, EXE, MEM, WB).
- Replaces the fixed, hazard-blind stage advance: owns an internal shadow of EXE/MEM/WB destination info and generates load-use stalls, branch flushes, EXE operand forwarding selects and cache-miss freeze.
- Adds a miss-timeout error state machine and a stall performance counter.
- Sits beside the top-level datapath and drives the stall/flush/enable pins of the PC and of the IF_ID, ID_EX, EXE_MEM and MEM_WB registers.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MISS_TIMEOUT, 255, consecutive miss cycles before the error state is entered (must be >= 1).
- CNT_W, 16, width of stall_count.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_ADDR_W  ID source register A.
- id_rt  in  REG_ADDR_W  ID source register B.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq).
- id_dest  in  REG_ADDR_W  final destination (already RegDst-muxed).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  PCSrc from EXE.
- imem_hit  in  1  instruction cache hit.
- dmem_hit  in  1  data cache hit.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF_ID.
- bubble_id_ex  out  1  load NOP (control = 0) into ID_EX.
- flush_if_id  out  1  load NOP into IF_ID.
- flush_id_ex  out  1  load NOP into ID_EX.
- freeze  out  1  hold every pipeline register and the PC.
- fwd_a  out  2  EXE operand A select.
- fwd_b  out  2  EXE operand B select.
- miss_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  saturating load-use stall cycle count.

Behaviour:
- Shadow entries S1 (EXE), S2 (MEM), S3 (WB), each holding {valid, rs, rt, dest, reg_write, mem_read}.
- Reset (async): all entries invalid, FSM = RUN, miss counter 0, stall_count 0, miss_error 0.
- With empty shadows after reset, all outputs are 0 except freeze, which follows the hit inputs.
- Advance on Clk when freeze = 0:
  - S3 <= S2, S2 <= S1.
  - S1 <= invalid if bubble_id_ex or flush_id_ex; otherwise the current ID inputs.
- When freeze = 1, no shadow entry changes.
- Match(Sk, r) = Sk.valid & Sk.reg_write & Sk.dest == r & r != 0. Register 0 is never forwarded or stalled on.
- fwd_a, combinational:
  - 2'b10 if Match(S2, S1.rs).
  - else 2'b01 if Match(S3, S1.rs).
  - else 2'b00.
  - MEM has priority over WB.
  - Result is 00 when S1 is invalid.
- fwd_b: same rule using S1.rt. 2'b11 is never driven.
- WB-to-ID same-cycle hazards are resolved by the register file (write-first); this block does not cover them.
- load_use = id_valid & S1.valid & S1.mem_read & S1.dest != 0 & (S1.dest == id_rs | (id_uses_rt & S1.dest == id_rt)).
- Branch (ex_branch_taken & !freeze): flush_if_id = flush_id_ex = 1 in the same cycle. A branch overrides load_use, so stall/bubble are forced to 0.
- Stall (load_use & !branch & !freeze): stall_pc = stall_if_id = bubble_id_ex = 1 for exactly one cycle. Next cycle the load is in S2, load_use is false and the consumer forwards from WB.
- freeze = !imem_hit | !dmem_hit | (state == ERR).
- While freeze = 1, stall, bubble and flush outputs are 0. fwd_a/fwd_b still reflect the held shadows.
- Miss FSM:
  - RUN: on any miss go to MISS, counter <= 1.
  - MISS: if both hits return to RUN and counter <= 0; else counter++. Entering MISS with counter == MISS_TIMEOUT goes to ERR.
  - ERR: sticky until Rst; miss_error = 1; freeze = 1.
- stall_count increments on each cycle with stall_pc = 1 and saturates at all-ones.
- Reset asserted mid-miss or mid-stall clears everything immediately; no pending stall survives reset.

Test Plan:
- lw $2 then add $3,$2,$4 back-to-back → one cycle of stall_pc/stall_if_id/bubble_id_ex = 1. Next cycle with add in EXE: fwd_a = 01. stall_count = 1.
- add $5,$1,$1; sub $6,$5,$5 → no stall; sub in EXE gets fwd_a = fwd_b = 10. With one independent instruction between them: 01/01.
- Writes to $0 followed by a reader of $0 → fwd = 00, no stall. lw $0 followed by a user → no stall.
- ex_branch_taken = 1 in the same cycle as load_use → flush_if_id = flush_id_ex = 1, stall_pc = 0. S1 becomes invalid, so the next fwd = 00.
- imem_hit = 0 for 3 cycles with MISS_TIMEOUT = 255 → freeze = 1 for exactly those cycles, shadows unchanged, then normal advance. Hold dmem_hit = 0 for 256 cycles → miss_error = 1 and freeze stays at 1 after the hit returns, until Rst.
- Assert Rst during a MISS state with a load in S1 → all outputs 0 and miss_error = 0 immediately; first post-reset cycle has no stall.
